// File: rtl/display_pkg.sv
// Shared types and constants for the six-digit scan controller.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int         NUM_DIGITS = 6;
    localparam logic [5:0] AN_OFF     = 6'b111111;
    localparam logic [2:0] SEL_LAST   = 3'd5;

    // Active-low one-cold anode pattern for a digit select code.
    function automatic logic [5:0] an_decode(input logic [2:0] sel);
        an_decode = AN_OFF & ~(6'b000001 << sel);
    endfunction

    // Next digit in scan order, wrapping after the last digit.
    function automatic logic [2:0] sel_advance(input logic [2:0] sel);
        sel_advance = (sel == SEL_LAST) ? 3'd0 : sel + 3'd1;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_scan_timer.sv
// Clear-able up-counter with a terminal-count compare, shared by the
// lit (dwell) and dark (blank) phases of the scan.
module scan_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [WIDTH-1:0] tc,
    output logic             done
);

    logic [WIDTH-1:0] count;

    // Count up each cycle; clr restarts the phase at zero.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else begin
            count <= count + WIDTH'(1);
        end
    end

    // Terminal-count equality; the owner clears before the counter can pass tc.
    assign done = (count == tc);

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for the six-digit seven-segment display.
// Drives selector code/enable and active-low anodes, and owns the two
// user-digit registers that are only updated while the display is dark at
// a frame boundary (or immediately when the scan is parked).
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int DWELL = 50000,
    parameter int BLANK = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       upd_valid,
    input  logic [3:0] upd_d5,
    input  logic [3:0] upd_d6,
    output logic       upd_ready,
    output logic [2:0] sel,
    output logic       mux_en,
    output logic [5:0] an,
    output logic [3:0] d5,
    output logic [3:0] d6,
    output logic       frame_done
);

    localparam int TMAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] DWELL_TC = TW'(DWELL - 1);
    localparam logic [TW-1:0] BLANK_TC = TW'(BLANK - 1);

    state_t        state;
    state_t        state_nxt;
    logic          timer_done;
    logic          timer_clr;
    logic [TW-1:0] timer_tc;

    logic [2:0]    sel_nxt;
    logic [5:0]    an_nxt;
    logic          mux_en_nxt;
    logic          boundary;

    logic          pend_full;
    logic [3:0]    pend_d5;
    logic [3:0]    pend_d6;
    logic          accept;
    logic          apply;

    // Phase timer: restarted on every state change and held at zero while parked.
    assign timer_tc  = (state == SHOW) ? DWELL_TC : BLANK_TC;
    assign timer_clr = (state == IDLE) || (state_nxt != state);

    scan_timer #(
        .WIDTH (TW)
    ) u_scan_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (timer_clr),
        .tc    (timer_tc),
        .done  (timer_done)
    );

    // Frame boundary: leaving the last digit's lit phase into its dark gap.
    assign boundary = (state == SHOW) && (state_nxt == GAP) && (sel == SEL_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; dropping en parks the scan from any state.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (en) state_nxt = SHOW;
            SHOW: begin
                if (!en)             state_nxt = IDLE;
                else if (timer_done) state_nxt = GAP;
            end
            GAP: begin
                if (!en)             state_nxt = IDLE;
                else if (timer_done) state_nxt = SHOW;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode from the next state so the registered outputs line up with it.
    always_comb begin
        sel_nxt    = sel;
        an_nxt     = AN_OFF;
        mux_en_nxt = 1'b0;
        case (state_nxt)
            IDLE: sel_nxt = 3'd0;
            SHOW: begin
                if (state == IDLE) sel_nxt = 3'd0;
                an_nxt     = an_decode(sel_nxt);
                mux_en_nxt = 1'b1;
            end
            GAP: begin
                // Advance on entry so the selector settles while anodes are dark.
                if (state == SHOW) sel_nxt = sel_advance(sel);
                mux_en_nxt = 1'b1;
            end
            default: sel_nxt = 3'd0;
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel        <= 3'd0;
            an         <= AN_OFF;
            mux_en     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            sel        <= sel_nxt;
            an         <= an_nxt;
            mux_en     <= mux_en_nxt;
            frame_done <= boundary;
        end
    end

    // A held update lands at a frame boundary, or right away while parked.
    assign accept = upd_valid && upd_ready;
    assign apply  = pend_full && (boundary || (state == IDLE));

    // Pending slot, user-digit registers and the ready flag; ready rises one
    // cycle after the slot drains so it never overlaps the apply cycle.
    // NOTE: the pending data and digit registers are reset too, so d5/d6 read zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_full <= 1'b0;
            pend_d5   <= 4'd0;
            pend_d6   <= 4'd0;
            d5        <= 4'd0;
            d6        <= 4'd0;
            upd_ready <= 1'b1;
        end else begin
            if (accept) begin
                pend_full <= 1'b1;
                pend_d5   <= upd_d5;
                pend_d6   <= upd_d6;
            end else if (apply) begin
                pend_full <= 1'b0;
            end
            if (apply) begin
                d5 <= pend_d5;
                d6 <= pend_d6;
            end
            upd_ready <= !accept && (upd_ready || !pend_full);
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with DWELL=4, BLANK=2.
module tb_display_scan_ctrl;

    localparam int DWELL = 4;
    localparam int BLANK = 2;
    localparam int SLOT  = DWELL + BLANK;
    localparam int FRAME = 6 * SLOT;

    localparam logic [10:0] IDLE_EXP = {6'h3F, 3'd0, 1'b0, 1'b0};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       upd_valid = 1'b0;
    logic [3:0] upd_d5 = 4'd0;
    logic [3:0] upd_d6 = 4'd0;
    logic       upd_ready;
    logic [2:0] sel;
    logic       mux_en;
    logic [5:0] an;
    logic [3:0] d5;
    logic [3:0] d6;
    logic       frame_done;

    int n_vec = 0;
    int n_err = 0;
    int c     = 0;

    display_scan_ctrl #(
        .DWELL (DWELL),
        .BLANK (BLANK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .upd_valid  (upd_valid),
        .upd_d5     (upd_d5),
        .upd_d6     (upd_d6),
        .upd_ready  (upd_ready),
        .sel        (sel),
        .mux_en     (mux_en),
        .an         (an),
        .d5         (d5),
        .d6         (d6),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected {an, sel, mux_en, frame_done} for cycle index cyc since scan start.
    function automatic logic [10:0] scan_exp(input int cyc);
        int         p;
        int         d;
        int         w;
        logic [5:0] a;
        logic [2:0] s;
        logic       fd;
        p  = cyc % FRAME;
        d  = p / SLOT;
        w  = p % SLOT;
        a  = 6'h3F;
        if (w < DWELL) begin
            a[d] = 1'b0;
            s    = 3'(d);
        end else begin
            s    = 3'((d + 1) % 6);
        end
        fd = (p == 5 * SLOT + DWELL);
        return {a, s, 1'b1, fd};
    endfunction

    task automatic step_scan(input string tag);
        @(posedge clk);
        c++;
        @(negedge clk);
        check(tag, 32'({an, sel, mux_en, frame_done}), 32'(scan_exp(c)));
    endtask

    task automatic step_idle(input string tag);
        @(posedge clk);
        @(negedge clk);
        check(tag, 32'({an, sel, mux_en, frame_done}), 32'(IDLE_EXP));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_an"},    32'(an),         32'h3F);
        check({tag, "_sel"},   32'(sel),        32'h0);
        check({tag, "_muxen"}, 32'(mux_en),     32'h0);
        check({tag, "_d"},     32'({d5, d6}),   32'h00);
        check({tag, "_ready"}, 32'(upd_ready),  32'h1);
        check({tag, "_fd"},    32'(frame_done), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;
        step_idle("idle_after_rst");
        step_idle("idle_hold");

        // Full scan: first frame.
        en = 1'b1;
        c  = -1;
        repeat (FRAME) step_scan("scan_f1");

        // Mid-frame update: held until the boundary, ready rises one cycle later.
        repeat (5) step_scan("scan_f2");
        upd_valid = 1'b1;
        upd_d5    = 4'h9;
        upd_d6    = 4'h3;
        check("ready_before_upd", 32'(upd_ready), 32'h1);
        step_scan("scan_f2");
        upd_valid = 1'b0;
        check("ready_fall", 32'(upd_ready), 32'h0);
        while (c < 69) begin
            step_scan("scan_f2");
            check("d_hold_mid", 32'({d5, d6}), 32'h00);
        end
        step_scan("scan_fd2");
        check("d_apply_fd", 32'({d5, d6}), 32'h93);
        check("ready_low_fd", 32'(upd_ready), 32'h0);
        step_scan("scan_f3");
        check("ready_rise", 32'(upd_ready), 32'h1);

        // Update accepted on the frame_done cycle waits a whole frame.
        while (c < 106) step_scan("scan_f3");
        upd_valid = 1'b1;
        upd_d5    = 4'hA;
        upd_d6    = 4'h5;
        check("ready_on_fd", 32'(upd_ready), 32'h1);
        step_scan("scan_f4");
        upd_valid = 1'b0;
        check("ready_fall_fd", 32'(upd_ready), 32'h0);
        check("d_not_on_fd", 32'({d5, d6}), 32'h93);
        while (c < 141) step_scan("scan_f4");
        check("d_hold_frame", 32'({d5, d6}), 32'h93);
        step_scan("scan_fd4");
        check("d_apply_next", 32'({d5, d6}), 32'hA5);
        step_scan("scan_f5");
        check("ready_rise2", 32'(upd_ready), 32'h1);

        // Drop en mid-SHOW of digit 3, then restart at digit 0.
        while (c < 163) step_scan("scan_f5");
        check("pre_drop_sel", 32'(sel), 32'h3);
        en = 1'b0;
        step_idle("en_drop");
        step_idle("en_drop_hold");
        en = 1'b1;
        c  = -1;
        repeat (SLOT) step_scan("restart");

        // Update while parked: applied the cycle after acceptance.
        en = 1'b0;
        step_idle("park");
        upd_valid = 1'b1;
        upd_d5    = 4'h9;
        upd_d6    = 4'h3;
        check("ready_idle", 32'(upd_ready), 32'h1);
        step_idle("idle_accept");
        upd_valid = 1'b0;
        check("idle_ready_fall", 32'(upd_ready), 32'h0);
        check("idle_d_pending", 32'({d5, d6}), 32'hA5);
        step_idle("idle_apply");
        check("idle_d_apply", 32'({d5, d6}), 32'h93);
        check("idle_ready_low", 32'(upd_ready), 32'h0);
        step_idle("idle_after");
        check("idle_ready_rise", 32'(upd_ready), 32'h1);

        // Asynchronous reset mid-GAP with an update pending.
        en = 1'b1;
        c  = -1;
        repeat (2) step_scan("pre_rst");
        upd_valid = 1'b1;
        upd_d5    = 4'h7;
        upd_d6    = 4'h7;
        step_scan("pre_rst");
        upd_valid = 1'b0;
        check("pre_rst_ready", 32'(upd_ready), 32'h0);
        repeat (2) step_scan("pre_rst_gap");
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b0;
        step_idle("post_rst");
        check("post_rst_d", 32'({d5, d6}), 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
